// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one main-memory block port between the I-cache miss path and the
// D-cache miss/write-back path. One block transaction is in flight at a time.
// Simultaneous requests are resolved round-robin using the side that was
// granted last.
//
// Handshake: a cache holds its request (i_read / d_read / d_write) and address
// (and write data) until it sees its one-cycle x_ready pulse. The arbiter
// latches address/op/data at grant time, so later input changes during the
// transaction are ignored. On the memory side the arbiter raises exactly one
// strobe (mem_read or mem_write) and holds it, with mem_addr/mem_wdata, until
// the cycle in which mem_ready=1. mem_ready is ignored outside a transaction.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_read, i_addr              I-cache block read request
//   i_rdata, i_ready            I-cache returned block / completion pulse
//   d_read, d_write, d_addr,    D-cache block request (write wins if both)
//   d_wdata
//   d_rdata, d_ready            D-cache returned block / completion pulse
//   mem_read, mem_write,        memory strobes and request fields
//   mem_addr, mem_wdata
//   mem_rdata, mem_ready        memory read data / completion
//   dbg_state                   current FSM state (IDLE=0, BUSY_I=1,
//                               BUSY_D=2, DONE=3)
//
// Every output is a register or a register copy; no input reaches an output
// combinationally.
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state_q, state_d;

    // 0: I-cache was granted last, 1: D-cache was granted last.
    logic              last_grant_d;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_write;

    logic i_req, d_req;
    logic grant_i, grant_d;

    // Grant decision, only acted upon in IDLE. On a tie the side that was
    // not granted last wins.
    always_comb begin
        i_req   = i_read;
        d_req   = d_read | d_write;
        grant_d = d_req & (~i_req | ~last_grant_d);
        grant_i = i_req & ~grant_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_i)      state_d = BUSY_I;
                else if (grant_d) state_d = BUSY_D;
            end
            BUSY_I:  if (mem_ready) state_d = DONE;
            BUSY_D:  if (mem_ready) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Registered datapath and strobes. The strobes are set on the grant edge
    // and cleared on the edge that observes mem_ready, so they are high
    // exactly while the FSM is in BUSY_I/BUSY_D.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_d <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_write    <= 1'b0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            i_rdata      <= '0;
            d_rdata      <= '0;
            i_ready      <= 1'b0;
            d_ready      <= 1'b0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_i) begin
                        lat_addr     <= i_addr;
                        lat_wdata    <= '0;
                        lat_write    <= 1'b0;
                        mem_read     <= 1'b1;
                        last_grant_d <= 1'b0;
                    end else if (grant_d) begin
                        // A simultaneous d_read/d_write is a write.
                        lat_addr     <= d_addr;
                        lat_wdata    <= d_wdata;
                        lat_write    <= d_write;
                        mem_read     <= ~d_write;
                        mem_write    <= d_write;
                        last_grant_d <= 1'b1;
                    end
                end
                BUSY_I: begin
                    if (mem_ready) begin
                        mem_read <= 1'b0;
                        i_rdata  <= mem_rdata;
                        i_ready  <= 1'b1;
                    end
                end
                BUSY_D: begin
                    if (mem_ready) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (!lat_write) d_rdata <= mem_rdata;
                        d_ready   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. A small memory model answers strobes
// after a programmable number of strobe cycles (or ties mem_ready high), and
// returns a block derived from the address. Requester tasks hold a request
// until their ready pulse, then drop it, and report the cycle count from
// request to ready.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          i_read = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_rdata;
    logic          i_ready;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;
    logic [1:0]    dbg_state;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_read    (i_read),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ready   (i_ready),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_q[$];   // expected grant order (0 = I, 1 = D)
    int done_q[$];             // observed completion order

    task automatic check_eq(input string tag, input logic [DW-1:0] obs,
                            input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- memory model ----------------
    int            mem_lat    = 4;
    logic          tie_ready  = 1'b0;
    int            strobe_cnt = 0;    // strobe cycles since last clear
    int            txn_cnt    = 0;
    logic [AW-1:0] cap_addr   = '0;   // fields seen on the completing cycle
    logic [DW-1:0] cap_wdata  = '0;
    logic          cap_wr     = 1'b0;

    function automatic logic [DW-1:0] model_data(input logic [AW-1:0] a);
        if (a == 28'h0000010) return {32{4'hA}};
        return {4{4'h5, a}};
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (mem_read || mem_write) begin
                strobe_cnt++;
                txn_cnt++;
            end else begin
                txn_cnt = 0;
            end
            mem_ready = tie_ready || ((mem_read || mem_write) && txn_cnt == mem_lat);
            if (mem_ready && (mem_read || mem_write)) begin
                cap_addr  = mem_addr;
                cap_wdata = mem_wdata;
                cap_wr    = mem_write;
                mem_rdata = model_data(mem_addr);
            end else begin
                mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    end

    // ---------------- protocol monitor ----------------
    int i_ready_cnt = 0;
    int d_ready_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (i_ready) i_ready_cnt++;
                if (d_ready) d_ready_cnt++;
                check_eq("strobe_mutex", DW'(mem_read & mem_write), '0);
                check_eq("ready_mutex", DW'(i_ready & d_ready), '0);
                check_eq("strobe_outside_busy",
                         DW'((mem_read | mem_write) & ~(dbg_state == 2'd1 || dbg_state == 2'd2)), '0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called right after a falling edge. cyc counts falling edges until the
    // ready pulse is seen; the request is dropped at that same falling edge.
    task automatic req_i(input logic [AW-1:0] a, output int cyc);
        logic ok;
        ok = 1'b0;
        cyc = 0;
        i_read = 1'b1;
        i_addr = a;
        while (cyc < 100 && !ok) begin
            @(negedge clk);
            cyc++;
            if (i_ready) ok = 1'b1;
        end
        i_read = 1'b0;
        check_eq("i_ready_timeout", DW'(ok), DW'(1));
        if (ok) done_q.push_back(0);
    endtask

    task automatic req_d(input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, output int cyc);
        logic ok;
        ok = 1'b0;
        cyc = 0;
        d_read  = ~wr;
        d_write = wr;
        d_addr  = a;
        d_wdata = wd;
        while (cyc < 100 && !ok) begin
            @(negedge clk);
            cyc++;
            if (d_ready) ok = 1'b1;
        end
        d_read  = 1'b0;
        d_write = 1'b0;
        check_eq("d_ready_timeout", DW'(ok), DW'(1));
        if (ok) done_q.push_back(1);
    endtask

    task automatic do_reset();
        i_read  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
        rst_n   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    int c_i, c_d;
    logic [DW-1:0] w1234, wcafe;

    initial begin
        w1234 = {8{16'h1234}};
        wcafe = {8{16'hCAFE}};

        // Reset state.
        @(negedge clk);
        check_eq("rst_mem_read", DW'(mem_read), '0);
        check_eq("rst_mem_write", DW'(mem_write), '0);
        check_eq("rst_mem_addr", DW'(mem_addr), '0);
        check_eq("rst_mem_wdata", mem_wdata, '0);
        check_eq("rst_i_rdata", i_rdata, '0);
        check_eq("rst_d_rdata", d_rdata, '0);
        check_eq("rst_i_ready", DW'(i_ready), '0);
        check_eq("rst_d_ready", DW'(d_ready), '0);
        check_eq("rst_state", DW'(dbg_state), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // I-only read, memory answers in the 4th strobe cycle.
        mem_lat = 4;
        strobe_cnt = 0;
        req_i(28'h0000010, c_i);
        check_eq("i_read_latency", DW'(c_i), DW'(5));
        check_eq("i_read_strobes", DW'(strobe_cnt), DW'(4));
        check_eq("i_read_addr", DW'(cap_addr), DW'(28'h0000010));
        check_eq("i_read_op", DW'(cap_wr), '0);
        check_eq("i_read_wdata", cap_wdata, '0);
        check_eq("i_read_data", i_rdata, {32{4'hA}});
        @(negedge clk);
        check_eq("i_ready_pulses", DW'(i_ready_cnt), DW'(1));
        check_eq("d_ready_quiet", DW'(d_ready_cnt), '0);

        // D read, then D write: the write must leave d_rdata alone.
        mem_lat = 2;
        req_d(1'b0, 28'h0000030, '0, c_d);
        check_eq("d_read_latency", DW'(c_d), DW'(3));
        check_eq("d_read_data", d_rdata, {4{32'h50000030}});
        check_eq("d_read_i_hold", i_rdata, {32{4'hA}});
        @(negedge clk);
        mem_lat = 3;
        strobe_cnt = 0;
        req_d(1'b1, 28'h0000020, w1234, c_d);
        check_eq("d_write_latency", DW'(c_d), DW'(4));
        check_eq("d_write_strobes", DW'(strobe_cnt), DW'(3));
        check_eq("d_write_op", DW'(cap_wr), DW'(1));
        check_eq("d_write_addr", DW'(cap_addr), DW'(28'h0000020));
        check_eq("d_write_wdata", cap_wdata, w1234);
        check_eq("d_write_rdata_hold", d_rdata, {4{32'h50000030}});
        check_eq("d_write_pulses", DW'(d_ready_cnt), DW'(2));

        // Inputs change while BUSY_D; memory must see the latched values.
        @(negedge clk);
        mem_lat = 6;
        fork
            req_d(1'b1, 28'h0000050, wcafe, c_d);
            begin
                repeat (3) @(negedge clk);
                d_addr  = 28'h0000077;
                d_wdata = {8{16'hBEEF}};
            end
        join
        check_eq("hold_addr", DW'(cap_addr), DW'(28'h0000050));
        check_eq("hold_wdata", cap_wdata, wcafe);

        // Simultaneous requests right after reset: D first, then I.
        do_reset();
        @(negedge clk);
        mem_lat = 2;
        done_q.delete();
        exp_q.delete();
        exp_q.push_back(1);
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(0);
        fork
            req_i(28'h0000040, c_i);
            req_d(1'b0, 28'h0000060, '0, c_d);
        join
        check_eq("sim1_d_latency", DW'(c_d), DW'(3));
        check_eq("sim1_i_latency", DW'(c_i), DW'(7));
        check_eq("sim1_i_data", i_rdata, {4{32'h50000040}});
        check_eq("sim1_d_data", d_rdata, {4{32'h50000060}});
        @(negedge clk);
        fork
            req_i(28'h0000044, c_i);
            req_d(1'b0, 28'h0000064, '0, c_d);
        join
        check_eq("sim2_d_latency", DW'(c_d), DW'(3));
        check_eq("sim2_i_latency", DW'(c_i), DW'(7));
        check_eq("sim2_i_data", i_rdata, {4{32'h50000044}});
        check_eq("sim2_d_data", d_rdata, {4{32'h50000064}});
        check_eq("grant_order_len", DW'(done_q.size()), DW'(4));
        while (exp_q.size() > 0 && done_q.size() > 0)
            check_eq("grant_order", DW'(done_q.pop_front()), exp_q.pop_front());

        // Zero-wait memory with back-to-back I then D.
        @(negedge clk);
        tie_ready = 1'b1;
        strobe_cnt = 0;
        req_i(28'h0000010, c_i);
        check_eq("zw_i_latency", DW'(c_i), DW'(2));
        check_eq("zw_i_strobes", DW'(strobe_cnt), DW'(1));
        check_eq("zw_i_data", i_rdata, {32{4'hA}});
        req_d(1'b0, 28'h0000070, '0, c_d);
        check_eq("zw_d_gap_latency", DW'(c_d), DW'(3));
        check_eq("zw_d_data", d_rdata, {4{32'h50000070}});
        check_eq("zw_total_strobes", DW'(strobe_cnt), DW'(2));
        tie_ready = 1'b0;

        // Asynchronous reset in the middle of BUSY_I.
        @(negedge clk);
        mem_lat = 10;
        i_read = 1'b1;
        i_addr = 28'h0000080;
        repeat (3) @(negedge clk);
        check_eq("abort_pre_strobe", DW'(mem_read), DW'(1));
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort_mem_read", DW'(mem_read), '0);
        check_eq("abort_mem_addr", DW'(mem_addr), '0);
        check_eq("abort_i_rdata", i_rdata, '0);
        check_eq("abort_d_rdata", d_rdata, '0);
        check_eq("abort_state", DW'(dbg_state), '0);
        i_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_lat = 3;
        req_i(28'h0000090, c_i);
        check_eq("post_abort_latency", DW'(c_i), DW'(4));
        check_eq("post_abort_addr", DW'(cap_addr), DW'(28'h0000090));
        check_eq("post_abort_data", i_rdata, {4{32'h50000090}});

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
